clk_div_counter: RTL

- Programmable integer clock divider, clocked by `clk1`.
- Produces the divided clock `clk2_out`, which feeds directly into the `Clock_Divider` buffer stage (its `clk1` input). It also produces a one-cycle `tick` enable aligned to each divided-clock rising edge.
- The divisor can be reloaded at runtime; the new value is applied only at a period boundary, so the buffered clock never sees a runt pulse.

---
 rtl/clk_div_counter_if.sv | 52 +++++
 rtl/clk_div_counter.sv | 110 +++++++++++
 2 files changed

// File: rtl/clk_div_counter_if.sv
// ---------------------------------------------------------------------------
// clk_div_counter_if
// Groups the control/status signals of clk_div_counter.
//   en        count enable (master -> slave)
//   div_val   requested divisor N (master -> slave)
//   div_load  one-cycle strobe that captures div_val (master -> slave)
//   div_ack   one-cycle pulse when a new divisor takes effect (slave -> master)
//   div_err   one-cycle pulse on a rejected load (slave -> master); exists
//             only when CLK_DIV_RANGE_CHECK_EN is defined
//   clk2_out  registered divided clock (slave -> master)
//   tick      one-cycle pulse on the first high cycle of clk2_out
// Handshake: div_load is a fire-and-forget strobe (no ready); the request is
// taken in the cycle it is high, and completion is reported by div_ack (or
// div_err) as a single-cycle pulse.
// ---------------------------------------------------------------------------
interface clk_div_counter_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic [WIDTH-1:0] div_val;
  logic             div_load;
  logic             div_ack;
`ifdef CLK_DIV_RANGE_CHECK_EN
  logic             div_err;
`endif
  logic             clk2_out;
  logic             tick;

  modport master (
    output en,
    output div_val,
    output div_load,
    input  div_ack,
`ifdef CLK_DIV_RANGE_CHECK_EN
    input  div_err,
`endif
    input  clk2_out,
    input  tick
  );

  modport slave (
    input  en,
    input  div_val,
    input  div_load,
    output div_ack,
`ifdef CLK_DIV_RANGE_CHECK_EN
    output div_err,
`endif
    output clk2_out,
    output tick
  );
endinterface

// File: rtl/clk_div_counter.sv
// ---------------------------------------------------------------------------
// clk_div_counter
// Programmable integer clock divider. Produces a registered divided clock
// (clk2_out, high ceil(N/2) / low floor(N/2) cycles, period N) that feeds the
// downstream Clock_Divider buffer stage, plus a one-cycle tick coincident with
// each clk2_out rising edge. A new divisor is only applied at a period
// boundary, so the buffered clock never sees a runt pulse.
//
// Ports:
//   clk1  source clock (single clock domain)
//   rst   synchronous, active-high reset
//   bus   clk_div_counter_if.slave (en, div_val, div_load, div_ack,
//         [div_err], clk2_out, tick)
//
// Configuration macro: CLK_DIV_RANGE_CHECK_EN
//   defined     -> loads with div_val < 2 are rejected and div_err pulses
//   not defined -> div_val < 2 is clamped to 2 and the load proceeds
// ---------------------------------------------------------------------------
module clk_div_counter #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic               clk1,
  input  logic               rst,
  clk_div_counter_if.slave   bus
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cur_div;
  logic [WIDTH-1:0] pend_div;
  logic             pend_valid;

  logic             clk2_q;
  logic             tick_q;
  logic             ack_q;

  logic             wrap;
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH:0]   half;

  // half is ceil(cur_div/2); one extra bit so cur_div = 2^WIDTH-1 cannot overflow
  always_comb begin
    wrap    = (cnt == (cur_div - 1'b1));
    cnt_inc = cnt + 1'b1;
    half    = ({1'b0, cur_div} + 1'b1) >> 1;
  end

`ifdef CLK_DIV_RANGE_CHECK_EN
  logic err_q;
  assign bus.div_err = err_q;
`endif

  always_ff @(posedge clk1) begin
    if (rst) begin
      cnt        <= WIDTH'(DEFAULT_DIV - 1);
      cur_div    <= WIDTH'(DEFAULT_DIV);
      pend_div   <= WIDTH'(DEFAULT_DIV);
      pend_valid <= 1'b0;
      clk2_q     <= 1'b0;
      tick_q     <= 1'b0;
      ack_q      <= 1'b0;
`ifdef CLK_DIV_RANGE_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      tick_q <= 1'b0;
      ack_q  <= 1'b0;
`ifdef CLK_DIV_RANGE_CHECK_EN
      err_q  <= 1'b0;
`endif

      if (bus.en) begin
        if (wrap) begin
          cnt    <= '0;
          clk2_q <= 1'b1;
          tick_q <= 1'b1;
          if (pend_valid) begin
            cur_div    <= pend_div;
            pend_valid <= 1'b0;
            ack_q      <= 1'b1;
          end
        end else begin
          cnt    <= cnt_inc;
          clk2_q <= ({1'b0, cnt_inc} < half);
        end
      end

      // Placed after the wrap logic on purpose: a load in the same cycle as a
      // wrap overrides the pend_valid clear, so it lands at the next wrap.
      if (bus.div_load) begin
`ifdef CLK_DIV_RANGE_CHECK_EN
        if (bus.div_val < WIDTH'(2)) begin
          err_q <= 1'b1;
        end else begin
          pend_div   <= bus.div_val;
          pend_valid <= 1'b1;
        end
`else
        pend_div   <= (bus.div_val < WIDTH'(2)) ? WIDTH'(2) : bus.div_val;
        pend_valid <= 1'b1;
`endif
      end
    end
  end

  assign bus.clk2_out = clk2_q;
  assign bus.tick     = tick_q;
  assign bus.div_ack  = ack_q;

endmodule
